// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: shared FSM state encoding for the chunked sequential adder
package seq_chunk_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// chunk_add: combinational CHUNK-bit slice adder with carry in/out
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: adds/subtracts WIDTH-bit operands CHUNK bits per cycle behind a valid/ready handshake
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, smask, sval;
  logic [KW-1:0] k;
  logic [CHUNK-1:0] s;
  logic carry, co, accept, last;
  assign accept = in_valid && in_ready;
  assign last = k == KLAST;
  // operands shift down each cycle, so the active chunk (and finally the MSB) sits in the low bits
  chunk_add #(.CHUNK(CHUNK)) u_add (
    .a (a_q[CHUNK-1:0]),
    .b (b_q[CHUNK-1:0]),
    .ci(carry),
    .s (s),
    .co(co)
  );
  assign smask = WIDTH'({CHUNK{1'b1}}) << (32'(k) * CHUNK);
  assign sval = WIDTH'(s) << (32'(k) * CHUNK);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (in_valid ? RUN : IDLE) :
                (state == RUN)  ? (last ? DONE : RUN) :
                                  (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      carry <= 1'b0;
      k <= '0;
      Sum <= '0;
      Cout <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_q <= A;
      b_q <= sub ? ~B : B;
      carry <= sub ? ~Cin : Cin;
      k <= '0;
    end else if (state == RUN) begin
      a_q <= a_q >> CHUNK;
      b_q <= b_q >> CHUNK;
      carry <= co;
      k <= last ? '0 : k + KW'(1);
      Sum <= (Sum & ~smask) | sval;
      if (last) begin
        Cout <= co;
        ovf <= (a_q[CHUNK-1] == b_q[CHUNK-1]) && (s[CHUNK-1] != a_q[CHUNK-1]);
      end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed vector bench for 16/4, 8/4 and 8/8 configurations
module tb_seq_chunk_adder;
  typedef struct {
    logic [15:0] a, b;
    logic cin, sb;
    logic [15:0] s;
    logic c, o;
  } vec_t;
  typedef struct {
    logic [7:0] a, b;
    logic cin, sb;
    logic [7:0] s;
    logic c, o;
  } vec8_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] a = '0, b = '0, sum;
  logic cin = 1'b0, sb = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic irdy, cout, ovf, ovld;
  logic [7:0] a8 = '0, b8 = '0, s84, s88;
  logic cin8 = 1'b0, sb8 = 1'b0, iv8 = 1'b0, or8 = 1'b0;
  logic ir84, c84, o84, v84, ir88, c88, o88, v88;
  int nv = 0, nf = 0;
  vec_t tv[10];
  vec8_t tv8[4];
  always #5 clk = ~clk;
  seq_chunk_adder u16 (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .sub(sb),
    .in_valid(iv), .in_ready(irdy), .Sum(sum), .Cout(cout), .ovf(ovf),
    .out_valid(ovld), .out_ready(ordy)
  );
  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u84 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .sub(sb8),
    .in_valid(iv8), .in_ready(ir84), .Sum(s84), .Cout(c84), .ovf(o84),
    .out_valid(v84), .out_ready(or8)
  );
  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u88 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .sub(sb8),
    .in_valid(iv8), .in_ready(ir88), .Sum(s88), .Cout(c88), .ovf(o88),
    .out_valid(v88), .out_ready(or8)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op16(input vec_t v, input string nm);
    int n;
    chk({nm, "/in_ready"}, 32'(irdy), 1);
    a = v.a; b = v.b; cin = v.cin; sb = v.sb; iv = 1'b1;
    tick();
    iv = 1'b0;
    n = 0;
    while (!ovld && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "/latency"}, 32'(n), 4);
    chk({nm, "/sum"}, 32'(sum), 32'(v.s));
    chk({nm, "/cout"}, 32'(cout), 32'(v.c));
    chk({nm, "/ovf"}, 32'(ovf), 32'(v.o));
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk({nm, "/out_valid_drop"}, 32'(ovld), 0);
    chk({nm, "/in_ready_back"}, 32'(irdy), 1);
  endtask
  task automatic op8(input vec8_t v, input string nm);
    int l84, l88;
    l84 = -1; l88 = -1;
    a8 = v.a; b8 = v.b; cin8 = v.cin; sb8 = v.sb; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (v84 && l84 < 0) l84 = n;
      if (v88 && l88 < 0) l88 = n;
    end
    chk({nm, "/lat84"}, 32'(l84), 2);
    chk({nm, "/lat88"}, 32'(l88), 1);
    chk({nm, "/sum84"}, 32'(s84), 32'(v.s));
    chk({nm, "/sum88"}, 32'(s88), 32'(v.s));
    chk({nm, "/cout84"}, 32'(c84), 32'(v.c));
    chk({nm, "/cout88"}, 32'(c88), 32'(v.c));
    chk({nm, "/ovf84"}, 32'(o84), 32'(v.o));
    chk({nm, "/ovf88"}, 32'(o88), 32'(v.o));
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk({nm, "/ir84"}, 32'(ir84), 1);
    chk({nm, "/ir88"}, 32'(ir88), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int hits;
    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tv[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tv[7] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    tv[8] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};
    tv[9] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tv8[0] = '{8'd10, 8'd12, 1'b1, 1'b0, 8'd23, 1'b0, 1'b0};
    tv8[1] = '{8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0};
    tv8[2] = '{8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0, 1'b1};
    tv8[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    repeat (3) tick();
    rst = 1'b0;
    chk("reset/in_ready", 32'(irdy), 1);
    chk("reset/out_valid", 32'(ovld), 0);
    chk("reset/sum", 32'(sum), 0);
    chk("reset/cout", 32'(cout), 0);
    chk("reset/ovf", 32'(ovf), 0);
    chk("reset/ir84", 32'(ir84), 1);
    chk("reset/ir88", 32'(ir88), 1);
    for (int i = 0; i < 10; i++) op16(tv[i], $sformatf("v16_%0d", i));
    for (int i = 0; i < 4; i++) op8(tv8[i], $sformatf("v8_%0d", i));
    // backpressure with in_valid held and inputs scrambled throughout
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sb = 1'b0; iv = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = ~cin; sb = ~sb;
      tick();
    end
    chk("bp/out_valid", 32'(ovld), 1);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom);
      tick();
      chk("bp/sum_hold", 32'(sum), 32'h3333);
      chk("bp/cout_hold", 32'(cout), 0);
      chk("bp/ovf_hold", 32'(ovf), 0);
      chk("bp/in_ready_low", 32'(irdy), 0);
      chk("bp/out_valid_hold", 32'(ovld), 1);
    end
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("bp/in_ready_after", 32'(irdy), 1);
    chk("bp/out_valid_after", 32'(ovld), 0);
    tick();
    chk("bp/not_queued", 32'(irdy), 1);
    chk("bp/sum_kept", 32'(sum), 32'h3333);
    // reset in the second RUN cycle
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sb = 1'b0; iv = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrun/in_ready", 32'(irdy), 1);
    chk("rstrun/out_valid", 32'(ovld), 0);
    chk("rstrun/sum", 32'(sum), 0);
    hits = 0;
    repeat (8) begin
      tick();
      if (ovld) hits++;
    end
    chk("rstrun/no_pulse", 32'(hits), 0);
    op16(tv[3], "rstrun/next");
    // reset wins over a simultaneous accept
    a = 16'h0001; b = 16'h0001; iv = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; iv = 1'b0;
    chk("rstacc/in_ready", 32'(irdy), 1);
    hits = 0;
    repeat (6) begin
      tick();
      if (ovld) hits++;
    end
    chk("rstacc/no_pulse", 32'(hits), 0);
    op16(tv[1], "rstacc/next");
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
